mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Arbitrates between the fetch-side request port (inst) and the EX/ME-side load/store port (data), which share one sram-like downstream memory port.
- One transaction is in flight at a time.
- Each accepted request is registered and driven downstream. The response is returned to the port that owns the transaction.
- excp_flush/ertn_flush cancel delivery of an in-flight inst response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_req  in  1  inst request, held until inst_addr_ok
inst_wr  in  1  write when 1 (always 0 for fetch, supported anyway)
inst_size  in  2  0=byte,1=half,2=word
inst_addr  in  ADDR_W  request address
inst_wstrb  in  4  byte strobes
inst_wdata  in  DATA_W  write data
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst response valid
inst_rdata  out  DATA_W  inst read data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/ADDR_W/4/DATA_W  same meaning, data port
data_addr_ok, data_data_ok  out  1 each  same meaning, data port
data_rdata  out  DATA_W  data read data
out_req  out  1  downstream request
out_wr  out  1  downstream write
out_size  out  2  downstream size
out_addr  out  ADDR_W  downstream address
out_wstrb  out  4  downstream strobes
out_wdata  out  DATA_W  downstream write data
out_addr_ok  in  1  downstream accepted request
out_data_ok  in  1  downstream response valid
out_rdata  in  DATA_W  downstream read data
excp_flush  in  1  exception flush
ertn_flush  in  1  ertn flush

Behaviour:
- flush = excp_flush | ertn_flush.

FSM states and transitions:
- IDLE:
  - Select a requester and assert its *_addr_ok combinationally in the same cycle.
  - Latch wr/size/addr/wstrb/wdata into out_* registers, set owner, go to ADDR.
  - Nothing selected: stay in IDLE.
- ADDR:
  - out_req=1.
  - out_addr_ok=1: go to DATA next cycle.
  - Otherwise hold; all out_* stay stable.
- DATA:
  - out_req=0.
  - out_data_ok=1: pass the response to the owner (combinational), then go to IDLE.
  - No new accept in the same cycle.

Selection rules (IDLE only):
- Only data_req: grant data.
- Only inst_req, flush=0: grant inst.
- inst_req while flush=1: never granted; inst_addr_ok=0 that cycle.
- Both request:
  - Grant the opposite of last_grant; last_grant updates on every grant.
  - If flush=1, the inst request is ineligible and data wins.

Response routing:
- inst_rdata and data_rdata are both driven from out_rdata.
- Only the owner's *_data_ok pulses, for exactly one cycle.
- out_data_ok while in IDLE or ADDR is ignored.

Cancel:
- flush while owner=inst in ADDR or DATA sets cancel=1.
- The downstream transaction still completes normally.
- On completion with cancel=1: inst_data_ok stays 0 and cancel clears.
- flush in the same cycle as completion also suppresses inst_data_ok.
- flush never affects data-owned transactions.

Fixed latency:
- Min accept→data_ok is 2 cycles: accept T0, out_req T1 with addr_ok, data_ok T2.
- Back-to-back accepts are ≥3 cycles apart.

Reset (resetn=0 at a clk edge):
- State=IDLE, cancel=0, last_grant=inst (first conflict goes to data).
- out_req=0; out_wr/out_size/out_addr/out_wstrb/out_wdata=0.
- All *_addr_ok and *_data_ok = 0.
- Reset mid-transaction abandons it with no response to either port.

Test Plan:
- data_req only, word read addr 0x1C00_0100; slave addr_ok T1, data_ok T2 rdata 0xDEADBEEF -> data_addr_ok T0, out_req T1 out_addr=0x1C000100, data_data_ok T2 data_rdata=0xDEADBEEF, inst_data_ok=0.
- inst_req and data_req together after reset -> data granted first; after completion inst granted next; with both still held, grants alternate inst/data.
- Slave stalls addr_ok 3 cycles on a data store (wstrb=4'b0011, wdata=0x0000_1234) -> out_req held 4 cycles, out_* unchanged, data_addr_ok only at the original accept.
- inst read owned and in DATA; excp_flush 1 cycle; slave data_ok 2 cycles later -> inst_data_ok never asserted, FSM returns to IDLE, next inst request served normally.
- inst_req and ertn_flush in the same IDLE cycle, data_req low -> inst_addr_ok=0, out_req stays 0 next cycle; inst granted the cycle after flush drops.
- resetn=0 while in ADDR -> next cycle out_req=0, state IDLE, no *_data_ok; a later request completes correctly.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like downstream port between the fetch (inst) and
// load/store (data) request ports, one transaction in flight at a time.
module mem_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [3:0]        inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              out_req,
    output logic              out_wr,
    output logic [1:0]        out_size,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_wstrb,
    output logic [DATA_W-1:0] out_wdata,
    input  logic              out_addr_ok,
    input  logic              out_data_ok,
    input  logic [DATA_W-1:0] out_rdata,

    input  logic              excp_flush,
    input  logic              ertn_flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_e;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              cancel_q, cancel_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic flush;
    logic idle;
    logic inst_elig;
    logic grant_inst;
    logic grant_data;
    logic done;

    assign flush     = excp_flush | ertn_flush;
    assign idle      = (state_q == S_IDLE) && resetn;
    assign inst_elig = inst_req && !flush;

    // On a conflict the port that did not win last time gets the grant.
    assign grant_data = idle && data_req &&
                        (!inst_elig || last_q == OWN_INST);
    assign grant_inst = idle && inst_elig &&
                        (!data_req || last_q == OWN_DATA);

    assign done = resetn && (state_q == S_DATA) && out_data_ok;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done && owner_q == OWN_INST &&
                          !cancel_q && !flush;
    assign data_data_ok = done && owner_q == OWN_DATA;
    assign inst_rdata   = out_rdata;
    assign data_rdata   = out_rdata;

    assign out_req   = (state_q == S_ADDR);
    assign out_wr    = wr_q;
    assign out_size  = size_q;
    assign out_addr  = addr_q;
    assign out_wstrb = wstrb_q;
    assign out_wdata = wdata_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cancel_d = cancel_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wstrb_d = data_wstrb;
                    wdata_d = data_wdata;
                    owner_d = OWN_DATA;
                    last_d  = OWN_DATA;
                    state_d = S_ADDR;
                end else if (grant_inst) begin
                    wr_d    = inst_wr;
                    size_d  = inst_size;
                    addr_d  = inst_addr;
                    wstrb_d = inst_wstrb;
                    wdata_d = inst_wdata;
                    owner_d = OWN_INST;
                    last_d  = OWN_INST;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (out_addr_ok) state_d = S_DATA;
                if (flush && owner_q == OWN_INST) cancel_d = 1'b1;
            end
            S_DATA: begin
                if (out_data_ok) begin
                    state_d  = S_IDLE;
                    cancel_d = 1'b0;
                end else if (flush && owner_q == OWN_INST) begin
                    cancel_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_INST;
            last_q   <= OWN_INST;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'd0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cancel_q <= cancel_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUT delivers.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        out_req, out_wr;
    logic [1:0]  out_size;
    logic [31:0] out_addr;
    logic [3:0]  out_wstrb;
    logic [31:0] out_wdata;
    logic        out_addr_ok, out_data_ok;
    logic [31:0] out_rdata;
    logic        excp_flush, ertn_flush;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .out_req(out_req), .out_wr(out_wr), .out_size(out_size),
        .out_addr(out_addr), .out_wstrb(out_wstrb), .out_wdata(out_wdata),
        .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok),
        .out_rdata(out_rdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every *_data_ok must match the head of the queue.
    always @(negedge clk) begin
        if (resetn && (inst_data_ok || data_data_ok)) begin
            checks++;
            if (inst_data_ok && data_data_ok) begin
                errors++;
                $display("FAIL resp_both: inst_data_ok and data_data_ok both 1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got %s rdata %h expected none",
                         data_data_ok ? "data" : "inst",
                         data_data_ok ? data_rdata : inst_rdata);
            end else begin
                resp_t e;
                logic [31:0] rd;
                e  = exp_q.pop_front();
                rd = data_data_ok ? data_rdata : inst_rdata;
                if (e.is_data !== data_data_ok || rd !== e.rdata) begin
                    errors++;
                    $display("FAIL resp: got port %0d rdata %h expected port %0d rdata %h",
                             data_data_ok, rd, e.is_data, e.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0;
        inst_wstrb = 4'hf; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2; data_addr = 0;
        data_wstrb = 4'hf; data_wdata = 0;
        out_addr_ok = 0; out_data_ok = 0; out_rdata = 0;
        excp_flush = 0; ertn_flush = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        inst_req = 1;
        data_req = 1;
        step();
        step();
        @(negedge clk);
        chk("rst_out_req", {31'd0, out_req}, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        inst_req = 0;
        data_req = 0;
        step();
        resetn = 1;
    endtask

    // Called in the accept cycle; plays the slave through to completion.
    // port: 0 none, 1 inst, 2 data.
    task automatic slave(input int stall, input logic [31:0] rd,
                         input logic [31:0] eaddr, input logic ewr,
                         input logic [3:0] ewstrb, input logic [31:0] ewdata,
                         input int port, input logic keep);
        resp_t r;
        step();
        if (!keep) begin
            inst_req = 0;
            data_req = 0;
        end
        for (int i = 0; i <= stall; i++) begin
            out_addr_ok = (i == stall);
            @(negedge clk);
            chk("addr_out_req", {31'd0, out_req}, 1);
            chk("addr_out_addr", out_addr, eaddr);
            chk("addr_out_ctl", {27'd0, out_wr, out_wstrb}, {27'd0, ewr, ewstrb});
            chk("addr_out_wdata", out_wdata, ewdata);
            chk("addr_no_accept", {30'd0, inst_addr_ok, data_addr_ok}, 0);
            step();
        end
        out_addr_ok = 0;
        out_data_ok = 1;
        out_rdata = rd;
        if (port != 0) begin
            r.is_data = (port == 2);
            r.rdata = rd;
            exp_q.push_back(r);
        end
        @(negedge clk);
        chk("data_out_req", {31'd0, out_req}, 0);
        step();
        out_data_ok = 0;
    endtask

    initial begin
        do_reset();

        // data read alone
        data_req = 1; data_addr = 32'h1C00_0100;
        @(negedge clk);
        chk("t1_accept", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(0, 32'hDEAD_BEEF, 32'h1C00_0100, 0, 4'hf, 0, 2, 0);
        @(negedge clk);
        chk("t1_out_size", {30'd0, out_size}, 2);

        // simultaneous requests after reset alternate data, inst, data
        do_reset();
        inst_req = 1; inst_addr = 32'h1C00_0000;
        data_req = 1; data_addr = 32'h0000_0200;
        @(negedge clk);
        chk("t2_first", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(0, 32'h1111_1111, 32'h0000_0200, 0, 4'hf, 0, 2, 1);
        @(negedge clk);
        chk("t2_second", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        slave(0, 32'h2222_2222, 32'h1C00_0000, 0, 4'hf, 0, 1, 1);
        @(negedge clk);
        chk("t2_third", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(0, 32'h3333_3333, 32'h0000_0200, 0, 4'hf, 0, 2, 0);

        // stalled store holds out_* stable
        data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h0000_0300;
        data_wstrb = 4'b0011; data_wdata = 32'h0000_1234;
        @(negedge clk);
        chk("t3_accept", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(3, 32'h0, 32'h0000_0300, 1, 4'b0011, 32'h0000_1234, 2, 0);
        data_wr = 0; data_wstrb = 4'hf; data_wdata = 0;

        // last grant was data, but a flush makes inst ineligible
        inst_req = 1; inst_addr = 32'h1C00_0010;
        data_req = 1; data_addr = 32'h0000_0400;
        excp_flush = 1;
        @(negedge clk);
        chk("t3b_flush_conflict", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(0, 32'hA5A5_5A5A, 32'h0000_0400, 0, 4'hf, 0, 2, 0);
        excp_flush = 0;

        // flush during inst DATA phase cancels the response
        inst_req = 1; inst_addr = 32'h1C00_0040;
        @(negedge clk);
        chk("t4_accept", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        step();
        inst_req = 0;
        out_addr_ok = 1;
        step();
        out_addr_ok = 0;
        excp_flush = 1;
        step();
        excp_flush = 0;
        step();
        out_data_ok = 1; out_rdata = 32'h4444_4444;
        @(negedge clk);
        chk("t4_cancelled", {31'd0, inst_data_ok}, 0);
        step();
        out_data_ok = 0;
        inst_req = 1; inst_addr = 32'h1C00_0044;
        @(negedge clk);
        chk("t4_next_accept", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        slave(0, 32'h5555_5555, 32'h1C00_0044, 0, 4'hf, 0, 1, 0);

        // flush in the completion cycle also suppresses inst_data_ok
        inst_req = 1; inst_addr = 32'h1C00_0048;
        @(negedge clk);
        chk("t4b_accept", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        step();
        inst_req = 0;
        out_addr_ok = 1;
        step();
        out_addr_ok = 0;
        out_data_ok = 1; out_rdata = 32'h6666_6666;
        ertn_flush = 1;
        @(negedge clk);
        chk("t4b_cancelled", {31'd0, inst_data_ok}, 0);
        step();
        out_data_ok = 0;
        ertn_flush = 0;

        // inst request blocked while ertn_flush is high
        inst_req = 1; inst_addr = 32'h1C00_0080;
        ertn_flush = 1;
        @(negedge clk);
        chk("t5_blocked", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        step();
        ertn_flush = 0;
        @(negedge clk);
        chk("t5_no_out_req", {31'd0, out_req}, 0);
        chk("t5_accept", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        slave(0, 32'h7777_7777, 32'h1C00_0080, 0, 4'hf, 0, 1, 0);

        // reset in ADDR abandons the transaction
        data_req = 1; data_addr = 32'h0000_0500;
        @(negedge clk);
        chk("t6_accept", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        step();
        data_req = 0;
        @(negedge clk);
        chk("t6_in_addr", {31'd0, out_req}, 1);
        resetn = 0;
        step();
        resetn = 1;
        out_data_ok = 1; out_rdata = 32'h8888_8888;
        @(negedge clk);
        chk("t6_out_req", {31'd0, out_req}, 0);
        chk("t6_out_addr", out_addr, 0);
        chk("t6_no_resp", {30'd0, inst_data_ok, data_data_ok}, 0);
        step();
        out_data_ok = 0;
        data_req = 1; data_addr = 32'h0000_0504;
        @(negedge clk);
        chk("t6_reaccept", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        slave(1, 32'h5566_7788, 32'h0000_0504, 0, 4'hf, 0, 2, 0);

        step();
        step();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
